// File: rtl/filter_ctrl_if.sv
// Start/done/ack handshake and result bus between filter_ctrl and the bounding-box filter.
interface filter_ctrl_if;
  logic       filt_start;
  logic       filt_ack;
  logic       filt_done;
  logic [8:0] filt_x_min;
  logic [8:0] filt_x_max;
  logic [8:0] filt_y_min;
  logic [8:0] filt_y_max;

  modport master (
    output filt_start, filt_ack,
    input  filt_done, filt_x_min, filt_x_max, filt_y_min, filt_y_max
  );

  modport slave (
    input  filt_start, filt_ack,
    output filt_done, filt_x_min, filt_x_max, filt_y_min, filt_y_max
  );
endinterface

// File: rtl/filter_ctrl.sv
// Scan sequencer for the colour bounding-box filter: start/done/ack handshake,
// box capture, optional periodic rescans and a watchdog on hung scans.
module filter_ctrl #(
  parameter int PERIOD_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          auto_mode,
  input  logic          trigger,
  input  logic          clr_err,
  filter_ctrl_if.master filt,
  output logic [8:0]    box_x_min,
  output logic [8:0]    box_x_max,
  output logic [8:0]    box_y_min,
  output logic [8:0]    box_y_max,
  output logic          box_found,
  output logic          box_update,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   frame_count
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, CAPTURE, ACK, HOLDOFF, ERROR
  } state_t;

  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic             start_second;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] timeout_cnt;
  logic             auto_run;
  logic             capture_now;

  assign auto_run    = enable && auto_mode;
  assign capture_now = (state == WAIT_DONE) && filt.filt_done;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Period counter runs from START entry and saturates; timeout counter only runs in WAIT_DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_second <= 1'b0;
      period_cnt   <= '0;
      timeout_cnt  <= '0;
    end else begin
      start_second <= (state == START) && !start_second;
      if ((next_state == START) && (state != START))
        period_cnt <= '0;
      else if (period_cnt != '1)
        period_cnt <= period_cnt + CNT_W'(1);
      if (state == START)
        timeout_cnt <= '0;
      else if (state == WAIT_DONE)
        timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (enable && (trigger || auto_mode)) next_state = START;
      START:     if (start_second) next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (filt.filt_done)                next_state = CAPTURE;
        else if (timeout_cnt >= TIMEOUT_LAST) next_state = ERROR;
      end
      CAPTURE:   next_state = ACK;
      ACK:       if (!filt.filt_done) next_state = auto_run ? HOLDOFF : IDLE;
      HOLDOFF: begin
        if (!auto_run)                      next_state = IDLE;
        else if (period_cnt >= PERIOD_LAST) next_state = START;
      end
      ERROR:     if (clr_err) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    filt.filt_start = 1'b0;
    filt.filt_ack   = 1'b0;
    box_update      = 1'b0;
    busy            = 1'b0;
    timeout_err     = 1'b0;
    case (state)
      START: begin
        filt.filt_start = 1'b1;
        busy            = 1'b1;
      end
      WAIT_DONE: busy = 1'b1;
      CAPTURE: begin
        box_update = 1'b1;
        busy       = 1'b1;
      end
      ACK: begin
        filt.filt_ack = 1'b1;
        busy          = 1'b1;
      end
      ERROR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  // Results latch on the edge into CAPTURE so the new box is visible while box_update is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_found   <= 1'b0;
      frame_count <= '0;
    end else if (capture_now) begin
      box_x_min   <= filt.filt_x_min;
      box_x_max   <= filt.filt_x_max;
      box_y_min   <= filt.filt_y_min;
      box_y_max   <= filt.filt_y_max;
      box_found   <= (filt.filt_x_min <= filt.filt_x_max) && (filt.filt_y_min <= filt.filt_y_max);
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: doc/filter_ctrl.md
Name: filter_ctrl

Overview:
- Sequencer for the colour-bounding-box filter. Issues its start, waits for done, and captures the box coordinates into stable output registers.
- Acknowledges the filter so it can return to idle. Optionally re-launches scans periodically.
- Detects a hung scan with a watchdog and reports it as a sticky error.
- Sits between the filter and the downstream consumer of the box (overlay/IO registers).

Parameters:
PERIOD_CYCLES, 1000000, minimum cycles from one scan start to the next in auto mode
TIMEOUT_CYCLES, 1048576, maximum cycles allowed in WAIT_DONE before error
CNT_W, 21, width of the period and timeout counters; must hold max(PERIOD_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  permits new scans
auto_mode  in  1  1 = periodic rescans, 0 = single-shot on trigger
trigger  in  1  single-cycle scan request
clr_err  in  1  clears timeout error, returns to IDLE
filt_done  in  1  filter done flag
filt_x_min, filt_x_max, filt_y_min, filt_y_max  in  9 each  filter results
filt_start  out  1  filter start flag
filt_ack  out  1  filter acknowledge flag
box_x_min, box_x_max, box_y_min, box_y_max  out  9 each  captured box
box_found  out  1  last capture contained an object
box_update  out  1  one-cycle pulse on each capture
busy  out  1  scan in progress
timeout_err  out  1  sticky watchdog error
frame_count  out  16  completed scans, wraps 0xFFFF -> 0

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; all counters clear.
  - Every output is 0.
  - Reset asserted mid-scan aborts immediately. filt_start and filt_ack go low the same edge.
- States: IDLE, START, WAIT_DONE, CAPTURE, ACK, HOLDOFF, ERROR.
- IDLE:
  - Go to START if enable && (trigger || auto_mode).
  - trigger is sampled only in IDLE; triggers in any other state are dropped, not queued.
- START:
  - filt_start=1 for exactly 2 cycles, which covers the filter leaving its own reset state.
  - Period counter clears on entry. Timeout counter clears.
  - Then go to WAIT_DONE.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - filt_done==1 -> CAPTURE; this takes priority over timeout in the same cycle.
  - Else if the timeout counter reaches TIMEOUT_CYCLES-1 -> ERROR.
- CAPTURE (1 cycle):
  - box_* registered from filt_* on this edge.
  - box_found = (filt_x_min <= filt_x_max) && (filt_y_min <= filt_y_max), 9-bit unsigned compare. A no-object scan returns min>max.
  - box_update=1 for this cycle only. frame_count+1.
  - Then go to ACK.
- ACK:
  - filt_ack=1 until filt_done samples 0, then deassert.
  - Next state: HOLDOFF if enable && auto_mode, else IDLE.
- HOLDOFF:
  - Period counter keeps counting from START entry.
  - Go to START when the count is >= PERIOD_CYCLES-1 and enable && auto_mode.
  - Go to IDLE immediately if enable==0 or auto_mode==0.
  - If the scan already exceeded the period, HOLDOFF lasts 1 cycle.
- ERROR:
  - timeout_err=1. filt_start=0, filt_ack=0.
  - No scans start. Stay until clr_err==1, then go to IDLE with timeout_err=0 next edge.
- enable dropping during START/WAIT_DONE does not abort (the filter has no abort). The scan completes, then the controller goes to IDLE.
- busy=1 in START, WAIT_DONE, CAPTURE, ACK; 0 otherwise.
- box_* and box_found hold their values between captures. They change only in CAPTURE or on reset.
- Period counter saturates at its maximum and does not wrap.

Test Plan:
Common bench settings: PERIOD_CYCLES=50, TIMEOUT_CYCLES=100. Filter behavioural model: done raised N cycles after start seen; done drops the cycle after ack seen.
1. Single shot:
   - Stimulus: enable=1, auto=0, one trigger pulse; model N=20 returning (x 10..50, y 20..60).
   - Required: filt_start high exactly 2 cycles; one box_update pulse; box=(10,50,20,60); box_found=1; frame_count=1; filt_ack high until done drops; busy falls; IDLE.
2. Auto periodic:
   - Stimulus: auto=1, N=20.
   - Required: filt_start rising edges exactly 50 cycles apart over 4 scans; frame_count=4.
   - Stimulus: then N=70.
   - Required: restart 1 cycle after the ACK state exits.
3. No object:
   - Stimulus: model returns x_min=319, x_max=0, y_min=239, y_max=0.
   - Required: box_update pulses; box registers = (319,0,239,0); box_found=0.
4. Timeout:
   - Stimulus: model never raises done.
   - Required: timeout_err=1 exactly 100 cycles after WAIT_DONE entry; busy=0; no further filt_start with auto=1.
   - Stimulus: clr_err pulse.
   - Required: timeout_err=0, IDLE, then a normal scan resumes.
5. Ignored trigger / enable drop:
   - Stimulus: trigger pulses during WAIT_DONE.
   - Required: no extra scan.
   - Stimulus: enable=0 mid-scan with auto=1.
   - Required: scan completes, captures, returns to IDLE, no restart.
6. Reset mid-scan:
   - Stimulus: reset=0 for 1 cycle during WAIT_DONE.
   - Required: all outputs 0 the next cycle, frame_count=0, controller idles until trigger.
